data_mem_lsu_ctrl: RTL and testbench

Load/store sequencer between the RV32I core's memory stage and the 64-word data memory. It accepts one load or store request at a time over a valid/ready handshake and sequences the memory's combinational read and single-cycle write. SB/SH are performed as read-modify-write. Load data is extracted and sign- or zero-extended. Misaligned, out-of-range and illegal-funct3 requests are rejected with an error response.

---
 rtl/data_mem_lsu_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_data_mem_lsu_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu_ctrl.sv
// Load/store sequencer between the core memory stage and a 64-word data memory.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
module data_mem_lsu_ctrl #(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_RESP  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [2:0]  funct3_q;
    logic        we_q;

    logic        accept;
    logic        f3_legal;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [31:0] merged_word;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    assign accept = req_valid_i && req_ready_o;

    // Request classification, only meaningful in the accept cycle.
    always_comb begin
        f3_legal = 1'b0;
        if (req_we_i) begin
            f3_legal = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
                       (req_funct3_i == 3'b010);
        end else begin
            case (req_funct3_i)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                default:                                f3_legal = 1'b0;
            endcase
        end
        misaligned   = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                       ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
        out_of_range = req_addr_i[31:2] >= 30'(MEM_WORDS);
        req_err      = !f3_legal || misaligned || out_of_range;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = S_ERR;
                    end else if (req_we_i && (req_funct3_i == 3'b010)) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = we_q ? S_WRITE : S_RESP;
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
                funct3_q <= req_funct3_i;
                we_q     <= req_we_i;
            end
            if (state_q == S_READ) begin
                rdata_q <= mem_rdata_i;
            end
        end
    end

    // Store merge: each byte lane picks new data or keeps the word read earlier.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic byte_hit;
        logic half_hit;
        logic word_hit;
        assign byte_hit = (funct3_q[1:0] == 2'b00) && (addr_q[1:0] == 2'(gi));
        assign half_hit = (funct3_q[1:0] == 2'b01) && (addr_q[1] == 1'(gi / 2));
        assign word_hit = (funct3_q[1:0] == 2'b10);
        assign merged_word[gi*8 +: 8] = byte_hit ? wdata_q[7:0] :
                                        half_hit ? wdata_q[(gi % 2)*8 +: 8] :
                                        word_hit ? wdata_q[gi*8 +: 8] :
                                                   rdata_q[gi*8 +: 8];
    end

    always_comb begin
        case (addr_q[1:0])
            2'b00:   load_byte = rdata_q[7:0];
            2'b01:   load_byte = rdata_q[15:8];
            2'b10:   load_byte = rdata_q[23:16];
            default: load_byte = rdata_q[31:24];
        endcase
        load_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'h0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'h0, load_half};
            3'b010:  load_data = rdata_q;
            default: load_data = '0;
        endcase
    end

    // Outputs depend only on state and latched fields, never on req_* directly.
    always_comb begin
        req_ready_o = (state_q == S_IDLE) && !rst_i;
        rsp_valid_o = 1'b0;
        rsp_err_o   = 1'b0;
        rsp_rdata_o = '0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        case (state_q)
            S_READ: begin
                mem_addr_o = {2'b00, addr_q[31:2]};
            end
            S_WRITE: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = {addr_q[31:2], 2'b00};
                mem_wdata_o = merged_word;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_rdata_o = we_q ? 32'h0 : load_data;
            end
            S_ERR: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_mem_lsu_ctrl.sv
// Randomized bench for data_mem_lsu_ctrl with a behavioural memory/ISA reference model.
module tb_data_mem_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    logic [31:0] tb_mem  [64];
    logic [31:0] ref_mem [64];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_lsu_ctrl #(.MEM_WORDS(64)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    // Data memory: combinational read by word index, write by byte address.
    assign mem_rdata_i = (mem_addr_o < 32'd64) ? tb_mem[mem_addr_o[5:0]] : 32'hBAD0BAD0;
    always @(posedge clk) begin
        if (mem_we_o && (mem_addr_o[31:8] == 24'h0)) tb_mem[mem_addr_o[7:2]] <= mem_wdata_o;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd);
        logic        legal, exp_err, err_o;
        int          sz, bsh, hsh, exp_lat, rsp_cyc, we_cnt, we_cyc, n;
        logic [31:0] word, mask, shifted, exp_rd, exp_wdata, exp_a1, a1, we_addr, we_data;
        sz  = int'(f3[1:0]);
        bsh = 8 * int'(addr[1:0]);
        hsh = 16 * int'(addr[1]);
        legal   = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        exp_err = !legal || (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00) ||
                  ((addr >> 2) >= 32'd64);
        exp_rd = 0;
        exp_wdata = 0;
        if (!exp_err) begin
            word = ref_mem[addr[7:2]];
            if (!we) begin
                if (sz == 2) exp_rd = word;
                else if (sz == 1) begin
                    exp_rd = (word >> hsh) & 32'hFFFF;
                    if (!f3[2] && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF0000;
                end else begin
                    exp_rd = (word >> bsh) & 32'hFF;
                    if (!f3[2] && exp_rd[7]) exp_rd = exp_rd | 32'hFFFFFF00;
                end
            end else begin
                mask    = (sz == 2) ? 32'hFFFFFFFF : (sz == 1) ? (32'hFFFF << hsh) : (32'hFF << bsh);
                shifted = (sz == 2) ? wd : (sz == 1) ? ((wd & 32'hFFFF) << hsh) : ((wd & 32'hFF) << bsh);
                exp_wdata = (word & ~mask) | (shifted & mask);
            end
        end
        exp_lat = exp_err ? 1 : (we && sz != 2) ? 3 : 2;
        exp_a1  = exp_err ? 32'h0 : (we && sz == 2) ? {addr[31:2], 2'b00} : (addr >> 2);

        n = 0;
        while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
        req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = addr; req_wdata_i = wd;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        rsp_cyc = 0; we_cnt = 0; we_cyc = 0; rd = 0; err_o = 0; a1 = 0; we_addr = 0; we_data = 0;
        for (int k = 1; k <= 6 && rsp_cyc == 0; k++) begin
            @(negedge clk);
            if (k == 1) a1 = mem_addr_o;
            if (mem_we_o) begin we_cnt++; we_cyc = k; we_addr = mem_addr_o; we_data = mem_wdata_o; end
            if (rsp_valid_o) begin rsp_cyc = k; rd = rsp_rdata_o; err_o = rsp_err_o; end
        end
        chk("latency", 32'(rsp_cyc), 32'(exp_lat));
        chk("err", {31'h0, err_o}, {31'h0, exp_err});
        chk("rdata", rd, exp_rd);
        chk("cyc1_addr", a1, exp_a1);
        chk("we_count", 32'(we_cnt), (we && !exp_err) ? 32'd1 : 32'd0);
        if (we && !exp_err) begin
            chk("we_cycle", 32'(we_cyc), 32'(exp_lat - 1));
            chk("we_addr", we_addr, {addr[31:2], 2'b00});
            chk("we_data", we_data, exp_wdata);
            ref_mem[addr[7:2]] = exp_wdata;
        end
        @(negedge clk);
        chk("rsp_pulse", {31'h0, rsp_valid_o}, 32'h0);
        chk("ready_back", {31'h0, req_ready_o}, 32'h1);
        $display("txn we=%0d f3=%0d addr=%h wd=%h -> rd=%h err=%0d lat=%0d",
                 we, f3, addr, wd, rd, err_o, rsp_cyc);
    endtask

    task automatic dir(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp);
        logic [31:0] rd;
        do_req(we, f3, addr, wd, rd);
        chk("dir_rdata", rd, exp);
    endtask

    initial begin
        logic [31:0] rd, a, w;
        logic        we;
        logic [2:0]  f3;
        int          r;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            tb_mem[i] = w;
            ref_mem[i] = w;
        end
        tb_mem[3] = 32'h8081F0F7;
        ref_mem[3] = 32'h8081F0F7;
        rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b0;
        req_addr_i = 32'h0; req_wdata_i = 32'h0;

        #3;
        chk("rst_ready", {31'h0, req_ready_o}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err_o}, 32'h0);
        chk("rst_rdata", rsp_rdata_o, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we_o}, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        #1 chk("ready_after_rst", {31'h0, req_ready_o}, 32'h1);
        @(negedge clk);

        dir(1'b0, 3'b010, 32'h0C, 32'h0, 32'h8081F0F7);
        dir(1'b0, 3'b000, 32'h0C, 32'h0, 32'hFFFFFFF7);
        dir(1'b0, 3'b100, 32'h0F, 32'h0, 32'h00000080);
        dir(1'b0, 3'b001, 32'h0E, 32'h0, 32'hFFFF8081);
        dir(1'b0, 3'b101, 32'h0C, 32'h0, 32'h0000F0F7);
        dir(1'b1, 3'b000, 32'h0D, 32'h000000AA, 32'h0);
        dir(1'b0, 3'b010, 32'h0C, 32'h0, 32'h8081AAF7);
        dir(1'b1, 3'b001, 32'h0E, 32'h00001234, 32'h0);
        dir(1'b0, 3'b010, 32'h0C, 32'h0, 32'h1234AAF7);
        dir(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0);
        dir(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF);
        dir(1'b0, 3'b010, 32'h0E, 32'h0, 32'h0);
        dir(1'b1, 3'b001, 32'h01, 32'h5555, 32'h0);
        dir(1'b0, 3'b010, 32'h100, 32'h0, 32'h0);
        dir(1'b0, 3'b011, 32'h0C, 32'h0, 32'h0);

        // Two loads with valid held high across the busy period.
        req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h0C;
        @(posedge clk);
        #1 req_addr_i = 32'h10;
        @(negedge clk); chk("busy_ready_c1", {31'h0, req_ready_o}, 32'h0);
        @(negedge clk);
        chk("busy_rsp1_valid", {31'h0, rsp_valid_o}, 32'h1);
        chk("busy_rsp1_data", rsp_rdata_o, ref_mem[3]);
        chk("busy_ready_c2", {31'h0, req_ready_o}, 32'h0);
        @(negedge clk); chk("busy_ready_idle", {31'h0, req_ready_o}, 32'h1);
        @(negedge clk);
        chk("busy_second_read", mem_addr_o, 32'h4);
        chk("busy_ready_c4", {31'h0, req_ready_o}, 32'h0);
        @(negedge clk);
        chk("busy_rsp2_valid", {31'h0, rsp_valid_o}, 32'h1);
        chk("busy_rsp2_data", rsp_rdata_o, ref_mem[4]);
        req_valid_i = 1'b0;
        $display("txn busy pair: LW 0x0C then LW 0x10 with valid held");
        @(negedge clk);

        // Reset asserted while an SB sits in WRITE.
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b000; req_addr_i = 32'h14;
        req_wdata_i = 32'h55;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk); chk("abort_read_addr", mem_addr_o, 32'h5);
        @(negedge clk); chk("abort_pre_we", {31'h0, mem_we_o}, 32'h1);
        rst_i = 1'b1;
        #1;
        chk("abort_we_drop", {31'h0, mem_we_o}, 32'h0);
        chk("abort_ready_rst", {31'h0, req_ready_o}, 32'h0);
        chk("abort_no_rsp", {31'h0, rsp_valid_o}, 32'h0);
        @(negedge clk);
        rst_i = 1'b0;
        #1 chk("abort_ready_rel", {31'h0, req_ready_o}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_quiet", {31'h0, rsp_valid_o}, 32'h0);
        end
        $display("txn reset during SB write at 0x14");
        dir(1'b0, 3'b010, 32'h14, 32'h0, ref_mem[5]);

        for (int t = 0; t < 200; t++) begin
            we = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r == 0) a = $urandom;
            else if (r == 1) a = 32'h100 + 32'($urandom_range(0, 15));
            else a = 32'($urandom_range(0, 255));
            r = int'($urandom_range(0, 9));
            if (r < 8) begin
                if (we) f3 = 3'($urandom_range(0, 2));
                else begin
                    r = int'($urandom_range(0, 4));
                    f3 = (r < 3) ? 3'(r) : 3'(r + 1);
                end
            end else f3 = 3'($urandom_range(0, 7));
            do_req(we, f3, a, $urandom, rd);
        end

        for (int i = 0; i < 64; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
